// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: boot hold, load-use stall, branch flush,
// memory-busy freeze with timeout, and saturating stall/flush counters.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// BOOT     | post-reset hold, ID/EX bubbled, PC and IF/ID frozen
// RUN      | normal issue; load-use stall and branch flush decided here
// MEM_WAIT | data memory busy, whole pipeline frozen, wait time counted
module hazard_ctrl #(
    parameter int BOOT_CYC = 4,
    parameter int MAX_WAIT = 255,
    parameter int WAIT_W   = 8,
    parameter int CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             IDEX_MemRead_i,
    input  logic [4:0]       IDEX_Rt_i,
    input  logic [4:0]       IFID_Rs_i,
    input  logic [4:0]       IFID_Rt_i,
    input  logic             branch_taken_i,
    input  logic             mem_busy_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             pipe_hold_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam logic [WAIT_W-1:0] BOOT_LAST = WAIT_W'(BOOT_CYC - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              timeout_q;
    logic [CNT_W-1:0]  stall_q, flush_q;

    logic load_use;
    logic issue_eval;
    logic stall_inc;
    logic flush_inc;
    logic timeout_set;

    // A load into $0 never produces a value worth waiting for.
    assign load_use = IDEX_MemRead_i && (IDEX_Rt_i != 5'd0) &&
                      ((IDEX_Rt_i == IFID_Rs_i) || (IDEX_Rt_i == IFID_Rt_i));

    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        pipe_hold_o   = 1'b0;
        issue_eval    = 1'b0;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;

        case (state_q)
            BOOT: begin
                idex_bubble_o = 1'b1;
                if (wait_q == BOOT_LAST) begin
                    state_d = RUN;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + WAIT_ONE;
                end
            end
            RUN: begin
                if (mem_busy_i) begin
                    pipe_hold_o = 1'b1;
                    state_d     = MEM_WAIT;
                    wait_d      = WAIT_ONE;
                end else begin
                    issue_eval = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (mem_busy_i) begin
                    pipe_hold_o = 1'b1;
                    if (wait_q != WAIT_MAX)
                        wait_d = wait_q + WAIT_ONE;
                end else begin
                    state_d    = RUN;
                    wait_d     = '0;
                    issue_eval = 1'b1;
                end
            end
            default: begin
                state_d       = BOOT;
                wait_d        = '0;
                idex_bubble_o = 1'b1;
            end
        endcase

        // The unfreeze cycle out of MEM_WAIT decides exactly like RUN.
        if (issue_eval) begin
            if (load_use) begin
                idex_bubble_o = 1'b1;
                stall_inc     = 1'b1;
            end else if (branch_taken_i) begin
                pc_write_o    = 1'b1;
                ifid_write_o  = 1'b1;
                ifid_flush_o  = 1'b1;
                flush_inc     = 1'b1;
            end else begin
                pc_write_o    = 1'b1;
                ifid_write_o  = 1'b1;
            end
        end
    end

    // Fires on the edge where the wait count reaches MAX_WAIT, including
    // the RUN->MEM_WAIT entry load when MAX_WAIT is 1.
    assign timeout_set = (state_d == MEM_WAIT) && (wait_d == WAIT_MAX);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= BOOT;
            wait_q    <= '0;
            timeout_q <= 1'b0;
            stall_q   <= '0;
            flush_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (timeout_set)
                timeout_q <= 1'b1;
            if (stall_inc && (stall_q != '1))
                stall_q <= stall_q + CNT_ONE;
            if (flush_inc && (flush_q != '1))
                flush_q <= flush_q + CNT_ONE;
        end
    end

    assign timeout_o   = timeout_q;
    assign stall_cnt_o = stall_q;
    assign flush_cnt_o = flush_q;

endmodule
